// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared constants and arbiter state type for uart_bridge
package uart_bridge_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; push on full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver, mid-bit sampling, one-cycle rx_done per good frame
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d, data_q, data_d;
    logic        done_q, done_d, meta_q, sync_q;

    assign rx_data = data_q;
    assign rx_done = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync_q) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_END) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == BIT_END) begin
                cnt_d   = '0;
                shift_d = {sync_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == BIT_END) begin
                state_d = RX_IDLE;
                if (sync_q) begin
                    done_d = 1'b1;
                    data_d = shift_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            meta_q  <= rx_serial;
            sync_q  <= meta_q;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 transmitter; tx_start ignored while a frame is in flight
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    logic          busy_q, busy_d, done_q, done_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign tx_serial = !busy_q || shift_q[0];
    assign tx_done   = done_q;

    always_comb begin
        busy_d  = busy_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q + 1'b1;
        done_d  = 1'b0;
        if (!busy_q) begin
            cnt_d = '0;
            if (tx_start) begin
                busy_d  = 1'b1;
                shift_d = {1'b1, tx_data, 1'b0};
                bit_d   = '0;
            end
        end else if (cnt_q == BIT_END) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                shift_d = {1'b1, shift_q[9:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shift_q <= '1;
            bit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_bridge.sv
// rtl/uart_bridge.sv - UART to host byte-stream bridge with RX/TX FIFOs and echo mode
module uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_serial,
    output logic                          tx_serial,
    input  logic                          echo_en,
    input  logic [DATA_W-1:0]             host_tx_data,
    input  logic                          host_tx_valid,
    output logic                          host_tx_ready,
    output logic [DATA_W-1:0]             host_rx_data,
    output logic                          host_rx_valid,
    input  logic                          host_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          rx_overflow,
    input  logic                          ovf_clr
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;

    logic [DATA_W-1:0] rx_byte, rx_head, tx_head;
    logic              rx_done, tx_done;
    logic              rx_pop, rx_full, rx_empty, tx_push, tx_pop, tx_full, tx_empty;
    logic              arb_rx_pop;
    arb_state_e        state_q, state_d;
    logic              tx_start_q, tx_start_d, rx_overflow_q, rx_overflow_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk(clk), .rst(rst), .rx_serial(rx_serial), .rx_data(rx_byte), .rx_done(rx_done)
    );

    uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
        .clk(clk), .rst(rst), .tx_start(tx_start_q), .tx_data(tx_data_q),
        .tx_serial(tx_serial), .tx_done(tx_done)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_done), .push_data(rx_byte), .pop(rx_pop),
        .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_data(host_tx_data), .pop(tx_pop),
        .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    assign host_rx_valid = !echo_en && !rx_empty;
    assign host_rx_data  = rx_head;
    assign host_tx_ready = !echo_en && !tx_full;
    assign tx_push       = host_tx_valid && host_tx_ready;
    assign rx_pop        = arb_rx_pop || (host_rx_valid && host_rx_ready);
    assign rx_overflow   = rx_overflow_q;

    // echo_en only steers the source here in IDLE, so a mid-frame toggle cannot disturb BUSY.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        arb_rx_pop = 1'b0;
        tx_pop     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (echo_en && !rx_empty) begin
                    arb_rx_pop = 1'b1;
                    tx_data_d  = rx_head;
                    tx_start_d = 1'b1;
                    state_d    = ARB_BUSY;
                end else if (!echo_en && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_head;
                    tx_start_d = 1'b1;
                    state_d    = ARB_BUSY;
                end
            end
            ARB_BUSY: if (tx_done) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        rx_overflow_d = rx_overflow_q;
        if (ovf_clr) rx_overflow_d = 1'b0;
        if (rx_done && rx_full && !rx_pop) rx_overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_bridge.sv
// tb/tb_uart_bridge.sv - scoreboard bench: stimulus queues expected bytes, monitors decode and compare
module tb_uart_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic       tx_serial;
    logic       echo_en = 1'b0;
    logic [7:0] host_tx_data = 8'h00;
    logic       host_tx_valid = 1'b0;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready = 1'b0;
    logic [2:0] rx_count, tx_count;
    logic       rx_overflow;
    logic       ovf_clr = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];

    uart_bridge #(.CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx_serial(rx_serial), .tx_serial(tx_serial),
        .echo_en(echo_en), .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
        .host_tx_ready(host_tx_ready), .host_rx_data(host_rx_data),
        .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .rx_count(rx_count), .tx_count(tx_count), .rx_overflow(rx_overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_serial = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (16) tick();
        end
        rx_serial = 1'b1;
        repeat (16) tick();
    endtask

    task automatic push_host(input logic [7:0] b);
        logic done;
        done = 1'b0;
        host_tx_data  = b;
        host_tx_valid = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            if (host_tx_ready) done = 1'b1;
            tick();
        end
        host_tx_valid = 1'b0;
        check("host_push_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_tx_left(input int left, input int budget);
        for (int i = 0; i < budget && exp_tx_q.size() > left; i++) tick();
        check("tx_drain", 32'(exp_tx_q.size()), 32'(left));
        repeat (20) tick();
    endtask

    task automatic wait_rx_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (dut.rx_done) seen = 1'b1;
            else tick();
        end
        check("rx_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic measure_latency();
        logic seen;
        int   n;
        wait_rx_done(seen);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (dut.tx_start_q) break;
        end
        check("echo_latency", 32'(n), 32'd2);
    endtask

    task automatic coincident_clr();
        logic seen;
        wait_rx_done(seen);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic wait_n(input int n, output logic ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    // Line monitor: decode tx_serial and compare against the expected-byte queue.
    initial begin
        logic [7:0] b;
        logic       ab, a1, stop;
        forever begin
            @(negedge clk);
            if (!rst && tx_serial == 1'b0) begin
                wait_n(8, ab);
                for (int i = 0; i < 8; i++) begin
                    wait_n(16, a1);
                    ab   = ab | a1;
                    b[i] = tx_serial;
                end
                wait_n(16, a1);
                ab   = ab | a1;
                stop = tx_serial;
                if (!ab) begin
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: actual %02h required none", b);
                    end else begin
                        check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
                        check("tx_stop", 32'(stop), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && host_rx_valid && host_rx_ready) begin
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL host_rx_unexpected: actual %02h required none", host_rx_data);
                end else begin
                    check("host_rx_data", 32'(host_rx_data), 32'(exp_rx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int zeros;
        repeat (2) tick();
        check("rst_tx_serial", 32'(tx_serial), 32'd1);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_overflow", 32'(rx_overflow), 32'd0);
        check("rst_host_rx_valid", 32'(host_rx_valid), 32'd0);
        check("rst_host_tx_ready", 32'(host_tx_ready), 32'd1);
        rst = 1'b0;
        repeat (4) tick();

        echo_en = 1'b1;
        tick();
        exp_tx_q.push_back(8'h42);
        fork
            send_byte(8'h42);
            measure_latency();
        join
        wait_tx_left(0, 600);

        echo_en = 1'b0;
        tick();
        foreach (exp_tx_q[i]) begin end
        exp_tx_q.push_back(8'hA5);
        exp_tx_q.push_back(8'h3C);
        exp_tx_q.push_back(8'h11);
        exp_tx_q.push_back(8'h22);
        exp_tx_q.push_back(8'h33);
        push_host(8'hA5);
        push_host(8'h3C);
        push_host(8'h11);
        push_host(8'h22);
        push_host(8'h33);
        check("fill_tx_count", 32'(tx_count), 32'd4);
        check("fill_host_tx_ready", 32'(host_tx_ready), 32'd0);
        wait_tx_left(0, 1500);

        exp_rx_q.push_back(8'h7E);
        send_byte(8'h7E);
        repeat (20) tick();
        check("hold_valid", 32'(host_rx_valid), 32'd1);
        check("hold_data", 32'(host_rx_data), 32'h7E);
        check("hold_rx_count", 32'(rx_count), 32'd1);
        host_rx_ready = 1'b1;
        tick();
        host_rx_ready = 1'b0;
        check("pop_rx_count", 32'(rx_count), 32'd0);
        check("pop_valid", 32'(host_rx_valid), 32'd0);

        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        repeat (4) tick();
        check("ovf_rx_count", 32'(rx_count), 32'd4);
        check("ovf_set", 32'(rx_overflow), 32'd1);
        pulse_clr();
        check("ovf_cleared", 32'(rx_overflow), 32'd0);
        fork
            send_byte(8'h06);
            coincident_clr();
        join
        check("ovf_set_wins", 32'(rx_overflow), 32'd1);
        check("ovf_rx_count_held", 32'(rx_count), 32'd4);
        for (int i = 1; i <= 4; i++) exp_tx_q.push_back(8'(i));
        echo_en = 1'b1;
        wait_tx_left(0, 1500);
        check("echo_drained_rx", 32'(rx_count), 32'd0);
        pulse_clr();
        check("ovf_cleared2", 32'(rx_overflow), 32'd0);

        echo_en = 1'b0;
        tick();
        send_byte(8'h99);
        repeat (4) tick();
        check("toggle_rx_loaded", 32'(rx_count), 32'd1);
        exp_tx_q.push_back(8'h5A);
        exp_tx_q.push_back(8'h99);
        exp_tx_q.push_back(8'h66);
        push_host(8'h5A);
        push_host(8'h66);
        repeat (40) tick();
        echo_en = 1'b1;
        wait_tx_left(1, 800);
        check("tx_fifo_retained", 32'(tx_count), 32'd1);
        echo_en = 1'b0;
        wait_tx_left(0, 600);

        push_host(8'h55);
        push_host(8'h77);
        repeat (60) tick();
        rst = 1'b1;
        tick();
        check("midrst_tx_serial", 32'(tx_serial), 32'd1);
        check("midrst_tx_count", 32'(tx_count), 32'd0);
        check("midrst_rx_count", 32'(rx_count), 32'd0);
        rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!tx_serial) zeros++;
        end
        check("midrst_no_frame", 32'(zeros), 32'd0);

        check("tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
        check("rx_q_empty", 32'(exp_rx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
